// File: rtl/truth_table_checker_pkg.sv
// Shared definitions for the truth-table checker.
// Holds the FSM state encoding, the default parameter values and a
// helper that sizes the settle timer.
package truth_table_checker_pkg;

    localparam int N_IN_DEF       = 3;
    localparam int SETTLE_CYC_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } tt_state_e;

    // A settle window of one cycle still needs a 1-bit register.
    function automatic int timer_width(input int settle);
        return (settle > 1) ? $clog2(settle) : 1;
    endfunction

endpackage

// File: rtl/truth_table_checker_if.sv
// Bus between the truth-table checker and its surroundings.
//   start / expected     : run request and truth table
//   dut_in / dut_out     : stimulus to and response from the unit under test
//   busy / done / pass   : run status
//   fail_count, first_fail_vec, first_fail_vld : run results
// The master modport is the checker itself; slave is the side that
// requests runs and hosts the unit under test.
interface truth_table_checker_if #(
    parameter int N_IN = 3
);
    logic                 start;
    logic [2**N_IN-1:0]   expected;
    logic [N_IN-1:0]      dut_in;
    logic                 dut_out;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [N_IN:0]        fail_count;
    logic [N_IN-1:0]      first_fail_vec;
    logic                 first_fail_vld;

    modport master (
        input  start, expected, dut_out,
        output dut_in, busy, done, pass, fail_count, first_fail_vec, first_fail_vld
    );

    modport slave (
        output start, expected, dut_out,
        input  dut_in, busy, done, pass, fail_count, first_fail_vec, first_fail_vld
    );
endinterface

// File: rtl/truth_table_checker_settle_timer.sv
// Settle-window timer for the truth-table checker.
// Down-counter loaded with SETTLE_CYC-1 on clr, decremented while en is
// high, and stopping at zero. tc is high while the count is zero, which
// marks the last cycle of the settle window.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : reload the counter
//   en         : count down
//   tc         : terminal count reached
module tt_settle_timer
    import truth_table_checker_pkg::*;
#(
    parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int            W    = timer_width(SETTLE_CYC);
    localparam logic [W-1:0]  LOAD = W'(SETTLE_CYC - 1);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= LOAD;
        end else if (clr) begin
            cnt_q <= LOAD;
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign tc = (cnt_q == '0);

endmodule

// File: rtl/truth_table_checker.sv
// Truth-table checker: sweeps every input vector into a combinational
// unit, waits a settle window, compares its 1-bit response against a
// latched truth table and reports pass/fail, mismatch count and the
// first failing vector.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : start/expected in, dut_in/dut_out to the unit under
//                test, busy/done/pass and result registers out
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | waiting for start; results of the last run held
// ST_WAIT  | dut_in applied, settle timer running
// ST_CHECK | compare dut_out with exp_q[vec]; advance or finish
// ST_DONE  | one-cycle done pulse, pass valid
module truth_table_checker
    import truth_table_checker_pkg::*;
#(
    parameter int N_IN       = N_IN_DEF,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    truth_table_checker_if.master  bus
);
    localparam logic [N_IN-1:0] LAST_VEC = '1;

    tt_state_e          state_q, state_d;
    logic [2**N_IN-1:0] exp_q;
    logic [N_IN-1:0]    vec_q;
    logic [N_IN:0]      fail_count_q;
    logic [N_IN-1:0]    first_fail_vec_q;
    logic               first_fail_vld_q;
    logic               pass_q;

    logic               timer_clr, timer_en, timer_tc;
    logic               mismatch;
    logic [N_IN:0]      fail_count_nxt;

    tt_settle_timer #(.SETTLE_CYC(SETTLE_CYC)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (timer_clr),
        .en    (timer_en),
        .tc    (timer_tc)
    );

    assign mismatch       = (bus.dut_out != exp_q[vec_q]);
    assign fail_count_nxt = fail_count_q + {{N_IN{1'b0}}, mismatch};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_clr = 1'b0;
        timer_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                timer_clr = 1'b1;
                if (bus.start) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                timer_en = 1'b1;
                if (timer_tc) state_d = ST_CHECK;
            end
            ST_CHECK: begin
                timer_clr = 1'b1;
                state_d   = (vec_q == LAST_VEC) ? ST_DONE : ST_WAIT;
            end
            ST_DONE: begin
                timer_clr = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // pass is resolved on the edge into DONE so it is already valid
    // while done is high; it includes the final compare.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q            <= '0;
            vec_q            <= '0;
            fail_count_q     <= '0;
            first_fail_vec_q <= '0;
            first_fail_vld_q <= 1'b0;
            pass_q           <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        exp_q            <= bus.expected;
                        vec_q            <= '0;
                        fail_count_q     <= '0;
                        first_fail_vld_q <= 1'b0;
                        pass_q           <= 1'b0;
                    end
                end
                ST_CHECK: begin
                    fail_count_q <= fail_count_nxt;
                    if (mismatch && !first_fail_vld_q) begin
                        first_fail_vec_q <= vec_q;
                        first_fail_vld_q <= 1'b1;
                    end
                    if (vec_q == LAST_VEC) begin
                        pass_q <= (fail_count_nxt == '0);
                    end else begin
                        vec_q <= vec_q + N_IN'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.dut_in         = vec_q;
    assign bus.busy           = (state_q == ST_WAIT) || (state_q == ST_CHECK);
    assign bus.done           = (state_q == ST_DONE);
    assign bus.pass           = pass_q;
    assign bus.fail_count     = fail_count_q;
    assign bus.first_fail_vec = first_fail_vec_q;
    assign bus.first_fail_vld = first_fail_vld_q;

endmodule

// File: tb/tb_truth_table_checker.sv
module tb_truth_table_checker;

    localparam int N_IN       = 3;
    localparam int SETTLE_CYC = 2;
    localparam int RUN_CYC    = (2**N_IN) * (SETTLE_CYC + 1);   // 24

    localparam logic [1:0] M_NAND = 2'd0;
    localparam logic [1:0] M_ONE  = 2'd1;
    localparam logic [1:0] M_AND  = 2'd2;

    typedef struct {
        int   done_cyc;
        logic pass;
        int   fail_count;
        logic vld;
        int   vec;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [1:0] mode;
    logic       model_out;
    int         cyc;
    int         n_cmp;
    int         n_bad;
    int         n_done;
    exp_t       sb_q[$];

    truth_table_checker_if #(.N_IN(N_IN)) bus ();

    truth_table_checker #(.N_IN(N_IN), .SETTLE_CYC(SETTLE_CYC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Unit under test: NAND3, stuck-at-1, or AND3; dut_in = {A,B,C}.
    always_comb begin
        model_out = 1'b0;
        case (mode)
            M_NAND:  model_out = ~&bus.dut_in;
            M_ONE:   model_out = 1'b1;
            M_AND:   model_out = &bus.dut_in;
            default: model_out = 1'b0;
        endcase
    end
    assign bus.dut_out = model_out;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse pops one expected result.
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            exp_t e;
            n_done++;
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got done at cyc %0d, expected none", cyc);
            end else begin
                e = sb_q.pop_front();
                chk("done_cycle", cyc, e.done_cyc);
                chk("pass", int'(bus.pass), int'(e.pass));
                chk("fail_count", int'(bus.fail_count), e.fail_count);
                chk("first_fail_vld", int'(bus.first_fail_vld), int'(e.vld));
                if (e.vld) chk("first_fail_vec", int'(bus.first_fail_vec), e.vec);
            end
        end
    end

    // Called at a negedge: raise start for one cycle and queue the result.
    task automatic issue(input logic [7:0] tt, input logic p, input int fc,
                         input logic v, input int fv, output int c);
        exp_t e;
        bus.expected = tt;
        bus.start    = 1'b1;
        c            = cyc;
        e.done_cyc   = cyc + RUN_CYC + 1;
        e.pass       = p;
        e.fail_count = fc;
        e.vld        = v;
        e.vec        = fv;
        sb_q.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(negedge clk);
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d pending results, expected 0", sb_q.size());
            sb_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int   c;
        int   d0;
        exp_t e;
        cyc    = 0;
        n_cmp  = 0;
        n_bad  = 0;
        n_done = 0;
        rst_n        = 1'b0;
        mode         = M_NAND;
        bus.start    = 1'b0;
        bus.expected = 8'h7F;

        // 1. reset values
        #12;
        chk("rst_dut_in", int'(bus.dut_in), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_pass", int'(bus.pass), 0);
        chk("rst_fail_count", int'(bus.fail_count), 0);
        chk("rst_first_fail_vld", int'(bus.first_fail_vld), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 2. good NAND3, vector stepping every 3 cycles
        issue(8'h7F, 1'b1, 0, 1'b0, 0, c);
        for (int k = 0; k < 8; k++) begin
            while (cyc < c + 2 + 3 * k) @(negedge clk);
            chk("dut_in_step", int'(bus.dut_in), k);
            chk("busy_in_run", int'(bus.busy), 1);
        end
        drain();
        repeat (5) @(negedge clk);
        chk("pass_held", int'(bus.pass), 1);
        chk("dut_in_held_last", int'(bus.dut_in), 7);
        chk("busy_idle", int'(bus.busy), 0);

        // 3. output stuck at 1: only vector 7 fails
        mode = M_ONE;
        issue(8'h7F, 1'b0, 1, 1'b1, 7, c);
        drain();

        // 4. AND3: every vector fails
        mode = M_AND;
        issue(8'h7F, 1'b0, 8, 1'b1, 0, c);
        drain();
        repeat (3) @(negedge clk);
        chk("pass_held_low", int'(bus.pass), 0);

        // 5. start and expected changed mid-run are ignored
        mode = M_NAND;
        issue(8'h7F, 1'b1, 0, 1'b0, 0, c);
        for (int i = 0; i < 100 && bus.dut_in != 3; i++) @(negedge clk);
        chk("reach_vec3", int'(bus.dut_in), 3);
        bus.start    = 1'b1;
        bus.expected = 8'h00;
        @(negedge clk);
        bus.start = 1'b0;
        drain();

        // 5b. start held high: back-to-back runs every 26 cycles
        bus.expected = 8'h7F;
        bus.start    = 1'b1;
        e.pass = 1'b1; e.fail_count = 0; e.vld = 1'b0; e.vec = 0;
        e.done_cyc = cyc + RUN_CYC + 1;
        sb_q.push_back(e);
        e.done_cyc = cyc + RUN_CYC + 1 + (RUN_CYC + 2);
        sb_q.push_back(e);
        repeat (30) @(negedge clk);
        bus.start = 1'b0;
        drain();

        // 6. reset mid-run while dut_in == 4
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 100 && bus.dut_in != 4; i++) @(negedge clk);
        chk("reach_vec4", int'(bus.dut_in), 4);
        d0 = n_done;
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_dut_in", int'(bus.dut_in), 0);
        chk("abort_done", int'(bus.done), 0);
        chk("abort_fail_count", int'(bus.fail_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("no_done_after_abort", n_done - d0, 0);
        issue(8'h7F, 1'b1, 0, 1'b0, 0, c);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
